crc_mem_array: RTL

//  Parametrised N-channel CRC-protected register store. Next generation of the MEM1/MEM2 demo memories.

---
 rtl/crc_mem_pkg.sv | 20 ++
 rtl/crc_mem_chan.sv | 49 ++++
 rtl/crc_mem_array.sv | 98 +++++++++
 3 files changed

// File: rtl/crc_mem_pkg.sv
// crc_mem_pkg: shared types, default polynomial and CRC helper for the CRC-protected register store
package crc_mem_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} scrub_state_t;
  localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;
  localparam int CRC_MAX_W = 32;
  localparam int DATA_MAX_W = 64;
  // MSB-first CRC over the low dw bits of data, init 0, no reflection, no final XOR, cw-bit result
  function automatic logic [CRC_MAX_W-1:0] crc_calc(input logic [DATA_MAX_W-1:0] data,
                                                    input logic [CRC_MAX_W-1:0] poly,
                                                    input int dw, input int cw);
    logic [CRC_MAX_W-1:0] c;
    logic [CRC_MAX_W-1:0] m;
    c = '0;
    m = (cw >= CRC_MAX_W) ? '1 : (32'd1 << cw) - 32'd1;
    for (int i = DATA_MAX_W - 1; i >= 0; i--)
      if (i < dw)
        c = ({c[CRC_MAX_W-2:0], 1'b0} ^ ((c[cw-1] ^ data[i]) ? poly : '0)) & m;
    return c;
  endfunction
endpackage

// File: rtl/crc_mem_chan.sv
// crc_mem_chan: one protected channel - data and CRC storage, live CRC compare and registered error flag
//   clk, rst   clock, asynchronous active-high reset
//   wr_en      load wr_data and its CRC
//   wr_data    write data
//   flip       bits to invert in stored data (fault injection; write takes priority)
//   data       stored data
//   mismatch   combinational CRC(data) != stored CRC
//   err        registered mismatch
module crc_mem_chan
  import crc_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CRC_W = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] flip,
  output logic [DATA_W-1:0] data,
  output logic              mismatch,
  output logic              err
);
  logic [DATA_W-1:0] data_d, data_q;
  logic [CRC_W-1:0] crc_d, crc_q, wr_crc, data_crc;
  logic err_d, err_q;
  assign wr_crc = CRC_W'(crc_calc(DATA_MAX_W'(wr_data), CRC_MAX_W'(CRC_POLY), DATA_W, CRC_W));
  assign data_crc = CRC_W'(crc_calc(DATA_MAX_W'(data_q), CRC_MAX_W'(CRC_POLY), DATA_W, CRC_W));
  always_comb begin
    data_d = wr_en ? wr_data : data_q ^ flip;
    crc_d = wr_en ? wr_crc : crc_q;
    err_d = data_crc != crc_q;
  end
  // zero data with zero CRC is self-consistent since CRC(0) = 0 with init 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      crc_q <= '0;
      err_q <= 1'b0;
    end else begin
      data_q <= data_d;
      crc_q <= crc_d;
      err_q <= err_d;
    end
  assign data = data_q;
  assign mismatch = err_d;
  assign err = err_q;
endmodule

// File: rtl/crc_mem_array.sv
// crc_mem_array: N-channel CRC-protected register store with scrub sweep and saturating error counter
//   clk, rst        clock, asynchronous active-high reset
//   wr_en/wr_data   per-channel write strobe and data (channel c = [c*DATA_W +: DATA_W])
//   rd_data         stored data
//   err_detected    registered per-channel CRC mismatch; err_any is their OR
//   err_clr/err_cnt clear and saturating count of cycles with a new error
//   scrub_start     start a sweep; scrub_busy in SCAN, scrub_done pulse in REPORT
//   scrub_err_cnt   failing channels found by the last sweep
//   inj_en/inj_ch/inj_bit  bit-flip fault injection, present only with CRC_MEM_FAULT_INJ_EN
module crc_mem_array
  import crc_mem_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int CRC_W = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT),
  parameter int CNT_W = 8,
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int SW = $clog2(NUM_CH + 1),
  localparam int BW = $clog2(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0]        err_detected,
  output logic                     err_any,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         err_cnt,
  input  logic                     scrub_start,
  output logic                     scrub_busy,
  output logic                     scrub_done,
`ifdef CRC_MEM_FAULT_INJ_EN
  input  logic                     inj_en,
  input  logic [IW-1:0]            inj_ch,
  input  logic [BW-1:0]            inj_bit,
`endif
  output logic [SW-1:0]            scrub_err_cnt
);
  logic [NUM_CH-1:0] mismatch;
  logic [DATA_W-1:0] flip [NUM_CH];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
`ifdef CRC_MEM_FAULT_INJ_EN
    // channels beyond NUM_CH never match, so out-of-range inj_ch is dropped
    assign flip[c] = (inj_en && 32'(inj_ch) == c) ? DATA_W'(1) << inj_bit : '0;
`else
    assign flip[c] = '0;
`endif
    crc_mem_chan #(.DATA_W(DATA_W), .CRC_W(CRC_W), .CRC_POLY(CRC_POLY)) u_chan (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en[c]),
      .wr_data(wr_data[c*DATA_W +: DATA_W]),
      .flip(flip[c]),
      .data(rd_data[c*DATA_W +: DATA_W]),
      .mismatch(mismatch[c]),
      .err(err_detected[c])
    );
  end
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  scrub_state_t state_d, state_q;
  logic [IW-1:0] idx_d, idx_q;
  logic [SW-1:0] acc_d, acc_q, acc_inc, scrub_err_cnt_d, scrub_err_cnt_q;
  logic rose, last;
  // the counter steps once per cycle in which any flag is about to rise, however many rise together
  assign rose = |(mismatch & ~err_detected);
  assign last = 32'(idx_q) == NUM_CH - 1;
  assign acc_inc = acc_q + SW'(mismatch[idx_q]);
  always_comb begin
    err_cnt_d = err_clr ? '0 : (rose && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    state_d = (state_q == IDLE && scrub_start) ? SCAN :
              (state_q == SCAN && last) ? REPORT :
              (state_q == REPORT) ? IDLE : state_q;
    idx_d = (state_q == SCAN) ? idx_q + 1'b1 : '0;
    acc_d = (state_q == SCAN) ? acc_inc : '0;
    scrub_err_cnt_d = (state_q == SCAN && last) ? acc_inc : scrub_err_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_cnt_q <= '0;
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      scrub_err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      scrub_err_cnt_q <= scrub_err_cnt_d;
    end
  assign err_any = |err_detected;
  assign err_cnt = err_cnt_q;
  assign scrub_busy = state_q == SCAN;
  assign scrub_done = state_q == REPORT;
  assign scrub_err_cnt = scrub_err_cnt_q;
endmodule
